// File: rtl/sap_timing_ring_if.sv
// Control/status bundle for the SAP timing ring: cycle controls in, timing states out.
interface sap_timing_ring_if #(
    parameter int unsigned NUM_STATES = 6,
    parameter int unsigned CNT_W      = 8
);
    localparam int unsigned IDXW = (NUM_STATES > 2) ? $clog2(NUM_STATES) : 1;

    logic [IDXW:0]           cyc_len;
    logic                    restart;
    logic                    hold;
    logic                    halt;
    logic [NUM_STATES-1:0]   t;
    logic [IDXW-1:0]         t_index;
    logic                    last;
    logic [CNT_W-1:0]        cycles;
    logic                    halted;
    logic                    err;

    // Control unit side: drives cycle controls, observes timing states.
    modport master (
        output cyc_len, restart, hold, halt,
        input  t, t_index, last, cycles, halted, err
    );

    // Ring side: consumes cycle controls, produces timing states.
    modport slave (
        input  cyc_len, restart, hold, halt,
        output t, t_index, last, cycles, halted, err
    );
endinterface

// File: rtl/sap_timing_ring.sv
// SAP timing ring: one-hot T1..Tn sequencer with run-time cycle length,
// restart, hold, sticky halt and a completed-cycle counter.
// State advances on the falling edge of clock; clr is async active-low.
// Optional feature macro: RING_SELF_CORRECT_EN (one-hot check and recovery, sets err).
module sap_timing_ring #(
    parameter int unsigned NUM_STATES = 6,
    parameter int unsigned CNT_W      = 8
) (
    input  logic               clock,
    input  logic               clr,
    sap_timing_ring_if.slave   bus
);
    localparam int unsigned IDXW = (NUM_STATES > 2) ? $clog2(NUM_STATES) : 1;
    localparam int unsigned LENW = IDXW + 1;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_e;

    state_e                 state_q;
    state_e                 state_d;
    logic [NUM_STATES-1:0]  t_q;
    logic [NUM_STATES-1:0]  t_d;
    logic [IDXW-1:0]        idx_q;
    logic [IDXW-1:0]        idx_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic [LENW-1:0]        len_eff_c;
    logic                   last_c;

`ifdef RING_SELF_CORRECT_EN
    logic                   err_q;
    logic                   err_d;
    logic                   bad_c;
`endif

    // Effective cycle length: out-of-range requests fall back to the full ring.
    always_comb begin
        len_eff_c = bus.cyc_len;
        if (bus.cyc_len == '0 || bus.cyc_len > LENW'(NUM_STATES)) begin
            len_eff_c = LENW'(NUM_STATES);
        end
    end

    // Final state of the cycle; also true when the length shrinks below the position.
    always_comb begin
        last_c = (state_q == RUN) && ({1'b0, idx_q} >= (len_eff_c - LENW'(1)));
    end

`ifdef RING_SELF_CORRECT_EN
    // Ring is corrupt if t is not exactly the one-hot decode of the index.
    always_comb begin
        bad_c = (t_q != (NUM_STATES'(1) << idx_q));
    end
`endif

    // FSM state register.
    always_ff @(negedge clock or negedge clr) begin
        if (!clr) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: halt is sticky, only clr returns to RUN.
    always_comb begin
        state_d = state_q;
        if (state_q == RUN && bus.halt) begin
            state_d = HALTED;
        end
    end

    // FSM outputs: next ring position, counter and error flag by rule priority.
    always_comb begin
        t_d   = t_q;
        idx_d = idx_q;
        cnt_d = cnt_q;
`ifdef RING_SELF_CORRECT_EN
        err_d = err_q;
`endif
        if (state_q == HALTED) begin
            t_d = '0;
        end else if (bus.halt) begin
            t_d   = '0;
            idx_d = '0;
        end
`ifdef RING_SELF_CORRECT_EN
        else if (bad_c) begin
            t_d   = NUM_STATES'(1);
            idx_d = '0;
            err_d = 1'b1;
        end
`endif
        else if (bus.hold) begin
            t_d = t_q;
        end else if (bus.restart || last_c) begin
            t_d   = NUM_STATES'(1);
            idx_d = '0;
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            t_d   = t_q << 1;
            idx_d = idx_q + IDXW'(1);
        end
    end

    // Ring, index and counter registers.
    always_ff @(negedge clock or negedge clr) begin
        if (!clr) begin
            t_q   <= NUM_STATES'(1);
            idx_q <= '0;
            cnt_q <= '0;
        end else begin
            t_q   <= t_d;
            idx_q <= idx_d;
            cnt_q <= cnt_d;
        end
    end

`ifdef RING_SELF_CORRECT_EN
    // Sticky corruption flag, cleared only by clr.
    always_ff @(negedge clock or negedge clr) begin
        if (!clr) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.t       = t_q;
    assign bus.t_index = idx_q;
    assign bus.last    = last_c;
    assign bus.cycles  = cnt_q;
    assign bus.halted  = (state_q == HALTED);

endmodule

// File: tb/tb_sap_timing_ring.sv
// Bench for sap_timing_ring: arithmetic reference model checked every rising edge,
// plus directed scenarios with literal expectations.
module tb_sap_timing_ring;
    localparam int unsigned N     = 6;
    localparam int unsigned CNT_W = 8;

    logic clock;
    logic clr;
    int   total = 0;
    int   bad   = 0;
    bit   chk_en;

    // Reference model: position, completed cycles, halt and error flags.
    int   m_pos;
    int   m_cyc;
    bit   m_halted;
    bit   m_err;

    int   seq [13] = '{0, 1, 2, 3, 4, 5, 0, 1, 2, 3, 4, 5, 0};

    sap_timing_ring_if #(.NUM_STATES(N), .CNT_W(CNT_W)) bus ();

    sap_timing_ring #(.NUM_STATES(N), .CNT_W(CNT_W)) dut (
        .clock (clock),
        .clr   (clr),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int eff_len(input int c);
        return (c >= 1 && c <= int'(N)) ? c : int'(N);
    endfunction

    function automatic bit m_last();
        return !m_halted && (m_pos >= eff_len(int'(bus.cyc_len)) - 1);
    endfunction

    // Model update on the falling edge, async clear.
    always @(negedge clock or negedge clr) begin
        if (!clr) begin
            m_pos = 0; m_cyc = 0; m_halted = 0; m_err = 0;
        end else if (m_halted) begin
            m_pos = m_pos;
        end else if (bus.halt) begin
            m_halted = 1; m_pos = 0;
        end else if (bus.hold) begin
            m_pos = m_pos;
        end else if (bus.restart || m_last()) begin
            m_pos = 0; m_cyc = (m_cyc + 1) % (1 << CNT_W);
        end else begin
            m_pos = m_pos + 1;
        end
    end

    // Per-cycle comparison against the model, away from the falling edge.
    always @(posedge clock) begin
        if (chk_en && clr) begin
            chk("m_t",       32'(bus.t),       m_halted ? 32'd0 : (32'd1 << m_pos));
            chk("m_t_index", 32'(bus.t_index), 32'(m_pos));
            chk("m_last",    32'(bus.last),    32'(m_last()));
            chk("m_cycles",  32'(bus.cycles),  32'(m_cyc));
            chk("m_halted",  32'(bus.halted),  32'(m_halted));
            chk("m_err",     32'(bus.err),     32'(m_err));
        end
    end

    task automatic edges(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    initial begin
        clock = 1'b1;
        clr = 1'b0;
        chk_en = 1'b1;
        bus.cyc_len = 4'd6;
        bus.restart = 1'b0;
        bus.hold = 1'b0;
        bus.halt = 1'b0;

        // Reset values.
        #12;
        chk("rst_t", 32'(bus.t), 32'h01);
        chk("rst_idx", 32'(bus.t_index), 32'd0);
        chk("rst_cycles", 32'(bus.cycles), 32'd0);
        chk("rst_halted", 32'(bus.halted), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        clr = 1'b1;

        // Full-length cycles: T1..T6,T1..T6,T1.
        chk("seq_t0", 32'(bus.t), 32'h01);
        for (int i = 1; i < 13; i++) begin
            edges(1);
            chk("seq_t", 32'(bus.t), 32'd1 << seq[i]);
            chk("seq_idx", 32'(bus.t_index), 32'(seq[i]));
        end
        chk("seq_cycles", 32'(bus.cycles), 32'd2);

        // Async clear mid-T4 with no clock edge.
        edges(3);
        chk("t4", 32'(bus.t), 32'h08);
        #2;
        clr = 1'b0;
        #1;
        chk("midrst_t", 32'(bus.t), 32'h01);
        chk("midrst_cycles", 32'(bus.cycles), 32'd0);
        chk("midrst_halted", 32'(bus.halted), 32'd0);
        edges(1);
        clr = 1'b1;

        // Short cycle of 4 states.
        bus.cyc_len = 4'd4;
        for (int i = 1; i <= 8; i++) begin
            edges(1);
            chk("short_t", 32'(bus.t), 32'd1 << (i % 4));
            chk("short_last", 32'(bus.last), 32'((i % 4) == 3));
        end
        chk("short_cycles", 32'(bus.cycles), 32'd2);
        edges(2);
        chk("short_t3", 32'(bus.t), 32'h04);
        bus.cyc_len = 4'd2;
        #1;
        chk("shrink_last", 32'(bus.last), 32'd1);
        edges(1);
        chk("shrink_t", 32'(bus.t), 32'h01);
        chk("shrink_cycles", 32'(bus.cycles), 32'd3);

        // Out-of-range and minimal lengths.
        bus.cyc_len = 4'd0;
        edges(5);
        chk("len0_t6", 32'(bus.t), 32'h20);
        chk("len0_last", 32'(bus.last), 32'd1);
        edges(1);
        chk("len0_cycles", 32'(bus.cycles), 32'd4);
        bus.cyc_len = 4'd7;
        edges(6);
        chk("len7_t", 32'(bus.t), 32'h01);
        chk("len7_cycles", 32'(bus.cycles), 32'd5);
        bus.cyc_len = 4'd1;
        edges(2);
        chk("len1_t", 32'(bus.t), 32'h01);
        chk("len1_cycles", 32'(bus.cycles), 32'd7);

        // Restart and hold.
        bus.cyc_len = 4'd6;
        edges(1);
        chk("rs_t2", 32'(bus.t), 32'h02);
        bus.restart = 1'b1;
        edges(1);
        chk("rs_t", 32'(bus.t), 32'h01);
        chk("rs_cycles", 32'(bus.cycles), 32'd8);
        bus.restart = 1'b0;
        edges(2);
        bus.hold = 1'b1;
        bus.restart = 1'b1;
        edges(1);
        chk("hold_t", 32'(bus.t), 32'h04);
        chk("hold_cycles", 32'(bus.cycles), 32'd8);
        bus.hold = 1'b0;
        bus.restart = 1'b0;
        edges(1);
        chk("release_t", 32'(bus.t), 32'h08);
        edges(2);
        bus.hold = 1'b1;
        edges(2);
        chk("hold_last_t", 32'(bus.t), 32'h20);
        chk("hold_last_cycles", 32'(bus.cycles), 32'd8);
        bus.hold = 1'b0;
        edges(1);
        chk("wrap_cycles", 32'(bus.cycles), 32'd9);

        // Sticky halt.
        edges(4);
        chk("halt_t5", 32'(bus.t), 32'h10);
        bus.halt = 1'b1;
        edges(1);
        chk("halt_t", 32'(bus.t), 32'd0);
        chk("halt_flag", 32'(bus.halted), 32'd1);
        chk("halt_idx", 32'(bus.t_index), 32'd0);
        chk("halt_last", 32'(bus.last), 32'd0);
        bus.halt = 1'b0;
        bus.restart = 1'b1;
        edges(3);
        chk("halted_t", 32'(bus.t), 32'd0);
        chk("halted_flag", 32'(bus.halted), 32'd1);
        chk("halted_cycles", 32'(bus.cycles), 32'd9);
        bus.restart = 1'b0;
        clr = 1'b0;
        #1;
        chk("unhalt_t", 32'(bus.t), 32'h01);
        chk("unhalt_flag", 32'(bus.halted), 32'd0);
        chk("unhalt_cycles", 32'(bus.cycles), 32'd0);
        edges(1);
        clr = 1'b1;

        // Corrupted ring at T3.
        edges(2);
        chk("pre_corrupt_t", 32'(bus.t), 32'h04);
        chk_en = 1'b0;
        force dut.t_q = 6'b000110;
        #1;
        release dut.t_q;
        edges(1);
`ifdef RING_SELF_CORRECT_EN
        chk("fix_t", 32'(bus.t), 32'h01);
        chk("fix_idx", 32'(bus.t_index), 32'd0);
        chk("fix_err", 32'(bus.err), 32'd1);
        chk("fix_cycles", 32'(bus.cycles), 32'd0);
`else
        chk("corrupt_t", 32'(bus.t), 32'h0c);
        chk("corrupt_idx", 32'(bus.t_index), 32'd3);
        chk("corrupt_err", 32'(bus.err), 32'd0);
`endif
        clr = 1'b0;
        #1;
        chk("clr_err", 32'(bus.err), 32'd0);
        edges(1);
        clr = 1'b1;
        chk_en = 1'b1;
        edges(3);
        chk("final_t", 32'(bus.t), 32'h08);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
